// File: rtl/sram_port_arbiter.sv
// Two-requester SRAM port arbiter: grants the single-port SRAM to a read or a
// write engine for a whole burst, alternating ownership on simultaneous requests.
module sram_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              rd_req,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              rd_beat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  input  logic              wr_req,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              wr_beat,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  output logic              wr_gnt,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_d,
  output logic [31:0]       sram_bweb,
  output logic              busy,
  output logic              proto_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OWN_RD = 2'd1;
  localparam logic [1:0] OWN_WR = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] beat_cnt;
  logic             last_wr;
  logic             rd_own;
  logic             wr_own;

  // Byte strobes (active-high) expanded to the SRAM's active-low bit mask.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '1;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{~strb[i]}};
    end
    return mask;
  endfunction

  assign rd_own = (state == OWN_RD);
  assign wr_own = (state == OWN_WR);
  assign rd_gnt = rd_own;
  assign wr_gnt = wr_own;
  assign busy   = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      last_wr   <= 1'b1;
      proto_err <= 1'b0;
    end else begin
      if ((rd_beat && !rd_own) || (wr_beat && !wr_own)) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          // On a tie the engine that did not own the SRAM last goes first.
          if (rd_req && (!wr_req || last_wr)) begin
            state    <= OWN_RD;
            beat_cnt <= rd_len;
            last_wr  <= 1'b0;
          end else if (wr_req) begin
            state    <= OWN_WR;
            beat_cnt <= wr_len;
            last_wr  <= 1'b1;
          end
        end
        OWN_RD: begin
          if (rd_beat) begin
            if (beat_cnt == '0) state <= IDLE;
            else beat_cnt <= beat_cnt - 1'b1;
          end
        end
        OWN_WR: begin
          if (wr_beat) begin
            if (beat_cnt == '0) state <= IDLE;
            else beat_cnt <= beat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the owner's beat is steered onto the SRAM pins.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    sram_bweb = '1;
    if (rd_own && rd_beat) begin
      sram_ceb = 1'b0;
      sram_a   = rd_addr;
    end else if (wr_own && wr_beat) begin
      sram_ceb  = 1'b0;
      sram_web  = 1'b0;
      sram_a    = wr_addr;
      sram_d    = wr_data;
      sram_bweb = strb_to_bweb(wr_strb);
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 14, SRAM word-address width.
- LEN_W, 8, burst length width; the length value is AXI-style (beats-1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- rd_req  in  1  read engine requests SRAM ownership.
- rd_len  in  LEN_W  read burst beats-1, sampled at grant.
- rd_beat  in  1  read engine issues one SRAM access this cycle.
- rd_addr  in  ADDR_W  read word address.
- rd_gnt  out  1  read engine owns SRAM.
- wr_req  in  1  write engine requests ownership.
- wr_len  in  LEN_W  write burst beats-1, sampled at grant.
- wr_beat  in  1  write engine issues one access this cycle.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  32  write data.
- wr_strb  in  4  byte strobes.
- wr_gnt  out  1  write engine owns SRAM.
- sram_ceb  out  1  SRAM chip enable, active-low.
- sram_web  out  1  SRAM write enable, active-low.
- sram_a  out  ADDR_W  SRAM address.
- sram_d  out  32  SRAM write data.
- sram_bweb  out  32  SRAM bit-write enable, active-low.
- busy  out  1  state is not IDLE.
- proto_err  out  1  sticky flag: a beat arrived from a requester without a grant.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, OWN_RD and OWN_WR; busy = (state != IDLE).
REQ-004 rd_gnt SHALL be 1 exactly in OWN_RD, and wr_gnt SHALL be 1 exactly in OWN_WR; both are registered state decodes and are never 1 together.
REQ-005 In IDLE, a request SHALL cause a transition on the next edge:
- only rd_req set -> OWN_RD;
- only wr_req set -> OWN_WR;
- both set -> the requester not granted most recently wins.
REQ-006 The last-owner pointer SHALL update on every grant; its reset value is "write", so the read engine wins the first tie.
REQ-007 Grant latency SHALL be exactly 1 cycle from request to grant with no other traffic.
REQ-008 On entry to OWN_x, a beat counter of LEN_W bits SHALL load x_len.
REQ-009 Each x_beat during OWN_x SHALL decrement the beat counter.
REQ-010 A beat taken while the counter is 0 SHALL be the final beat; the state returns to IDLE on that edge, so the grant drops the following cycle.
REQ-011 A length of 0 SHALL mean one beat; the maximum length of 2^LEN_W-1 SHALL NOT wrap early.
REQ-012 Deasserting x_req while owning SHALL NOT release the grant; release happens only on the final beat.
REQ-013 Each release SHALL insert exactly one IDLE cycle before any next grant; a pending opposite request is granted on the cycle after IDLE.
REQ-014 SRAM outputs SHALL be combinational from the state and the owner's inputs:
- OWN_RD with rd_beat: ceb=0, web=1, a=rd_addr, bweb=all ones, d=0.
- OWN_WR with wr_beat: ceb=0, web=0, a=wr_addr, d=wr_data, bweb[8i+7:8i]=~wr_strb[i].
- Otherwise: ceb=1, web=1, a=0, d=0, bweb=all ones.
REQ-015 A beat from a non-owner SHALL NOT reach the SRAM outputs; it sets proto_err, which stays 1 until reset.
REQ-016 A beat in IDLE SHALL likewise set proto_err; both beats in the same cycle are handled per requester independently.

Reset
REQ-017 While ARESET=1 at an edge, the block SHALL load: state=IDLE, beat counter=0, last-owner=write, proto_err=0.
REQ-018 The resulting outputs during and after reset SHALL be: rd_gnt=wr_gnt=busy=0, ceb=1, web=1, a=0, d=0, bweb=FFFFFFFF.
REQ-019 Reset asserted mid-burst SHALL abandon the burst; no SRAM access is issued in the cycle after reset is sampled.

Verification
REQ-020 Tie after reset: rd_req=wr_req=1 in the same cycle -> rd_gnt=1 the next cycle. After rd_len=0 and one rd_beat: IDLE for one cycle, then wr_gnt=1.
REQ-021 Write burst: wr_len=3, four wr_beat with wr_strb=4'b0101 -> four cycles of web=0 with bweb=FF00FF00; wr_gnt drops after the 4th beat; busy=0 on the next cycle.
REQ-022 Stalled beats: rd_len=2 with beats on cycles 1, 4 and 5, and rd_req dropped at cycle 2 -> rd_gnt held through cycle 5 and released after the 3rd beat; ceb=0 only on beat cycles.
REQ-023 Intruder: wr_beat=1 during OWN_RD -> web stays 1, sram_a follows rd_addr, proto_err=1 and stays set until ARESET.
REQ-024 Mid-burst reset: ARESET pulsed after 2 of 8 write beats -> all grants are 0 next cycle and ceb=1. A new rd_req is then granted first, since last-owner is write.
REQ-025 Full length: rd_len=255 -> exactly 256 beats accepted before release.
